// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder time-sharing one full_adder, LSB first
// Ports: clk, rst (async, active-high), start/a/b/cin (request, captured in IDLE),
//        busy (RUN or DONE), done (1-cycle pulse), sum/cout (registered result),
//        ovf (signed overflow, only with SERIAL_ADDER_OVF_EN defined)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,output logic            ovf
`endif
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [CW-1:0] cnt;
  logic carry, fa_sum, fa_cout;
  logic [WIDTH:0] sum_cat;
  full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .sum(fa_sum), .cout(fa_cout));
  // concatenation keeps the shift legal when WIDTH is 1
  assign sum_cat = {fa_sum, sum_sr};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= cin;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_cat[WIDTH:1];
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= sum_cat[WIDTH:1];
            cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ fa_cout;
`endif
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for WIDTH=8 and WIDTH=1 serial adders
module tb_serial_adder_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, cin8 = 1'b0, start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic busy8, done8, cout8, busy1, done1, cout1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf1;
`endif
  int cyc = 0, n_vec = 0, n_err = 0;
  typedef struct {logic [7:0] s; logic c; logic o; int t;} exp_t;
  exp_t q8[$], q1[$];

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );
  serial_adder_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (done8) begin
    exp_t e;
    if (q8.size() == 0) chk("spurious_done8", 1, 0);
    else begin
      e = q8.pop_front();
      chk("sum8", int'(sum8), int'(e.s));
      chk("cout8", int'(cout8), int'(e.c));
      chk("done8_cycle", cyc, e.t);
      chk("busy8_with_done", int'(busy8), 1);
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf8", int'(ovf8), int'(e.o));
`endif
    end
  end

  always @(negedge clk) if (done1) begin
    exp_t e;
    if (q1.size() == 0) chk("spurious_done1", 1, 0);
    else begin
      e = q1.pop_front();
      chk("sum1", int'(sum1), int'(e.s));
      chk("cout1", int'(cout1), int'(e.c));
      chk("done1_cycle", cyc, e.t);
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf1", int'(ovf1), int'(e.o));
`endif
    end
  end

  // drive one start pulse; done is expected WIDTH edges after the start edge
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] s, input logic c, input logic o, input bit track);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    if (track) q8.push_back('{s, c, o, cyc + 1 + 8});
    @(posedge clk);
    #1 start8 = 1'b0;
    chk("busy8_rise", int'(busy8), 1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [7:0] s, input logic c, input logic o);
    issue8(a, b, ci, s, c, o, 1'b1);
    repeat (9) @(posedge clk);
  endtask

  typedef struct {logic a; logic b; logic ci; logic s; logic c; logic o;} v1_t;
  v1_t tt[8] = '{
    '{0,0,0, 0,0,0}, '{0,0,1, 1,0,1}, '{0,1,0, 1,0,0}, '{0,1,1, 0,1,0},
    '{1,0,0, 1,0,0}, '{1,0,1, 0,1,0}, '{1,1,0, 0,1,1}, '{1,1,1, 1,1,0}};

  initial begin
    #2;
    chk("reset_sum8", int'(sum8), 0);
    chk("reset_cout8", int'(cout8), 0);
    chk("reset_busy8", int'(busy8), 0);
    chk("reset_done8", int'(done8), 0);
    @(negedge clk);
    rst = 1'b0;
    op8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
    op8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    // start while busy and operand changes mid-RUN must be ignored
    issue8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
    repeat (8) @(posedge clk);
    #1 chk("no_second_op_busy", int'(busy8), 0);
    repeat (4) @(posedge clk);
    #1 chk("still_idle_busy", int'(busy8), 0);
    // asynchronous reset mid-RUN aborts without done
    issue8(8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_sum8", int'(sum8), 0);
    chk("abort_cout8", int'(cout8), 0);
    chk("abort_busy8", int'(busy8), 0);
    chk("abort_done8", int'(done8), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = tt[i].a; b1 = tt[i].b; cin1 = tt[i].ci; start1 = 1'b1;
      q1.push_back('{{7'b0, tt[i].s}, tt[i].c, tt[i].o, cyc + 1 + 1});
      @(posedge clk);
      #1 start1 = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
